// File: rtl/pipe_step_ctrl_pkg.sv
// Shared pipeline definitions: opcode constants plus the
// debug-step command and controller state encodings.
package pipe_step_ctrl_pkg;

    localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
    localparam logic [31:0] INSN_HALT  = 32'h0010_0073;

    typedef enum logic [1:0] {
        CMD_RUN   = 2'b00,
        CMD_STEP  = 2'b01,
        CMD_PAUSE = 2'b10,
        CMD_CLEAR = 2'b11
    } dbg_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } step_state_e;

endpackage

// File: rtl/pipe_step_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones; clear beats increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         i_reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_step_ctrl.sv
// Debug run/step/pause controller driving the pipeline freeze,
// with HALT drain sequencing and an advanced-cycle counter.
module pipe_step_ctrl
    import pipe_step_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_cmd_valid,
    input  logic [1:0]       i_cmd,
    output logic             o_cmd_ready,
    input  logic             i_halt_decoded,
    output logic             o_step,
    output logic [2:0]       o_state,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic             o_done
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD =
        (DRAIN_CYCLES > 0) ? DW'(DRAIN_CYCLES - 1) : '0;
    localparam bit NO_DRAIN = (DRAIN_CYCLES == 0);

    step_state_e   state_q, state_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          step_q;
    logic          done_q;
    logic          cmd_acc;
    logic          clr;
    dbg_cmd_e      cmd;

    assign cmd         = dbg_cmd_e'(i_cmd);
    assign o_cmd_ready = (state_q == ST_IDLE) || (state_q == ST_RUN) ||
                         (state_q == ST_HALTED);
    assign cmd_acc     = i_cmd_valid && o_cmd_ready;

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        clr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_acc) begin
                    case (cmd)
                        CMD_RUN:   state_d = ST_RUN;
                        CMD_STEP:  state_d = ST_STEP;
                        CMD_CLEAR: clr = 1'b1;
                        default:   state_d = ST_IDLE;
                    endcase
                end
            end
            ST_RUN, ST_STEP: begin
                // A decoded HALT swallows any command accepted alongside it
                if (i_halt_decoded) begin
                    if (NO_DRAIN) begin
                        state_d = ST_HALTED;
                    end else begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_LOAD;
                    end
                end else if (state_q == ST_STEP) begin
                    state_d = ST_IDLE;
                end else if (cmd_acc && (cmd == CMD_PAUSE)) begin
                    state_d = ST_IDLE;
                end else if (cmd_acc && (cmd == CMD_CLEAR)) begin
                    clr = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_HALTED;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            ST_HALTED: begin
                if (cmd_acc && (cmd == CMD_CLEAR)) begin
                    clr     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            drain_q <= '0;
            step_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            step_q  <= (state_d == ST_IDLE) || (state_d == ST_HALTED);
            done_q  <= (state_d == ST_HALTED) && (state_q != ST_HALTED);
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk     (clk),
        .i_reset (i_reset),
        .clr     (clr),
        .inc     (!step_q),
        .cnt     (o_cycle_cnt)
    );

    assign o_step  = step_q;
    assign o_state = state_q;
    assign o_done  = done_q;

endmodule
